// File: rtl/mix_state_assembler_pkg.sv
// Shared AES state types for the MixColumns writeback path.
// Used by mix_state_assembler and state_layout_mux (STATE_ASM_COLMAJOR_EN selects the layout).
package mix_state_assembler_pkg;

    localparam int unsigned NUM_ROWS = 4;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  row_t;
    typedef logic [15:0]  half_row_t;

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } asm_state_e;

    // Row bytes ordered col 0..3 from the MSB: beat 0 holds cols 0-1, beat 1 holds cols 2-3.
    function automatic row_t assemble_row(input half_row_t beat0, input half_row_t beat1);
        return {beat0[15:8], beat0[7:0], beat1[15:8], beat1[7:0]};
    endfunction

endpackage

// File: rtl/mix_state_assembler_state_layout_mux.sv
// Maps four AES rows onto the 128-bit state bus.
// STATE_ASM_COLMAJOR_EN selects column-major byte order; otherwise rows are concatenated.
module state_layout_mux
    import mix_state_assembler_pkg::*;
(
    input  logic [31:0]  row0_i,
    input  logic [31:0]  row1_i,
    input  logic [31:0]  row2_i,
    input  logic [31:0]  row3_i,
    output logic [127:0] state_o
);

    row_t rows [NUM_ROWS];

    always_comb begin
        rows[0] = row0_i;
        rows[1] = row1_i;
        rows[2] = row2_i;
        rows[3] = row3_i;
    end

`ifdef STATE_ASM_COLMAJOR_EN
    // col c = {row0[c], row1[c], row2[c], row3[c]}, byte c counted from the row MSB.
    always_comb begin
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                state_o[127 - 32 * c - 8 * r -: 8] = rows[r][31 - 8 * c -: 8];
            end
        end
    end
`else
    always_comb begin
        state_o = {rows[0], rows[1], rows[2], rows[3]};
    end
`endif

endmodule

// File: rtl/mix_state_assembler.sv
// Collects two beats of half-rows into one AES state and holds it for the writeback stage.
// Output byte order is selected by STATE_ASM_COLMAJOR_EN (column-major) or row-major by default.
module mix_state_assembler
    import mix_state_assembler_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  halfRow0,
    input  logic [15:0]  halfRow1,
    input  logic [15:0]  halfRow2,
    input  logic [15:0]  halfRow3,
    input  logic         inValid,
    output logic         inReady,
    input  logic         clear,
    output logic [127:0] stateOut,
    output logic         outValid,
    input  logic         outReady,
    output logic         beatIdx
);

    asm_state_e state_q;
    logic       out_valid_q;
    logic       beat_idx_q;
    half_row_t  beat0_q [NUM_ROWS];
    half_row_t  beat1_q [NUM_ROWS];
    half_row_t  half_row_in [NUM_ROWS];
    row_t       rows [NUM_ROWS];

    always_comb begin
        half_row_in[0] = halfRow0;
        half_row_in[1] = halfRow1;
        half_row_in[2] = halfRow2;
        half_row_in[3] = halfRow3;
        for (int r = 0; r < NUM_ROWS; r++) begin
            rows[r] = assemble_row(beat0_q[r], beat1_q[r]);
        end
    end

    // A held state may leave in the same cycle a new beat 0 arrives.
    assign inReady = (state_q != FULL) || outReady;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            beat_idx_q  <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                beat0_q[r] <= '0;
                beat1_q[r] <= '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (inValid) begin
                        for (int r = 0; r < NUM_ROWS; r++) beat0_q[r] <= half_row_in[r];
                        state_q    <= HALF;
                        beat_idx_q <= 1'b1;
                    end
                end
                HALF: begin
                    if (inValid) begin
                        for (int r = 0; r < NUM_ROWS; r++) beat1_q[r] <= half_row_in[r];
                        state_q     <= FULL;
                        out_valid_q <= 1'b1;
                        beat_idx_q  <= 1'b0;
                    end
                end
                FULL: begin
                    if (outReady) begin
                        out_valid_q <= 1'b0;
                        if (inValid) begin
                            for (int r = 0; r < NUM_ROWS; r++) beat0_q[r] <= half_row_in[r];
                            state_q    <= HALF;
                            beat_idx_q <= 1'b1;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    beat_idx_q  <= 1'b0;
                end
            endcase
        end
    end

    // Both buffers are frozen while FULL, so the mapped state is stable until consumed.
    state_layout_mux u_layout (
        .row0_i  (rows[0]),
        .row1_i  (rows[1]),
        .row2_i  (rows[2]),
        .row3_i  (rows[3]),
        .state_o (stateOut)
    );

    assign outValid = out_valid_q;
    assign beatIdx  = beat_idx_q;

endmodule

// File: tb/tb_mix_state_assembler.sv
// Self-checking bench for mix_state_assembler; honours STATE_ASM_COLMAJOR_EN for expected layout.
module tb_mix_state_assembler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid = 1'b0;
    logic         clear = 1'b0;
    logic         outReady = 1'b0;
    logic [15:0]  hr0 = '0, hr1 = '0, hr2 = '0, hr3 = '0;
    logic         inReady, outValid, beatIdx;
    logic [127:0] stateOut;

    always #5 clk = ~clk;

    mix_state_assembler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .halfRow0 (hr0),
        .halfRow1 (hr1),
        .halfRow2 (hr2),
        .halfRow3 (hr3),
        .inValid  (inValid),
        .inReady  (inReady),
        .clear    (clear),
        .stateOut (stateOut),
        .outValid (outValid),
        .outReady (outReady),
        .beatIdx  (beatIdx)
    );

    localparam logic [63:0] V0 = 64'h0001_1011_2021_3031;
    localparam logic [63:0] V1 = 64'h0203_1213_2223_3233;
    localparam logic [63:0] K  = 64'h4444_4444_4444_4444;
`ifdef STATE_ASM_COLMAJOR_EN
    localparam logic [127:0] EXP_LIT = 128'h00102030_01112131_02122232_03132333;
`else
    localparam logic [127:0] EXP_LIT = 128'h00010203_10111213_20212223_30313233;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    bit run = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte matrix view: m[row][col], cols 0-1 from beat 0, cols 2-3 from beat 1.
    function automatic logic [127:0] layout(input logic [63:0] b0, input logic [63:0] b1);
        logic [7:0]   m [4][4];
        logic [127:0] res;
        for (int r = 0; r < 4; r++) begin
            m[r][0] = b0[63 - 16 * r -: 8];
            m[r][1] = b0[55 - 16 * r -: 8];
            m[r][2] = b1[63 - 16 * r -: 8];
            m[r][3] = b1[55 - 16 * r -: 8];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
`ifdef STATE_ASM_COLMAJOR_EN
                res[127 - 32 * c - 8 * r -: 8] = m[r][c];
`else
                res[127 - 32 * r - 8 * c -: 8] = m[r][c];
`endif
            end
        end
        return res;
    endfunction

    // Model: count of beats held (0, 1, or 2 = full state waiting).
    int           m_cnt = 0;
    logic [63:0]  m_b0 = '0;
    logic [63:0]  m_b1 = '0;
    logic [127:0] m_state = '0;
    logic         m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [63:0] hin;
        bit          acc;
        hin = {hr0, hr1, hr2, hr3};
        if (!rst_n || clear) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_b0    = '0;
            m_b1    = '0;
        end else begin
            acc = inValid && (m_cnt < 2 || outReady);
            if (m_cnt == 2 && outReady) begin
                m_cnt   = 0;
                m_valid = 1'b0;
            end
            if (acc) begin
                if (m_cnt == 0) begin
                    m_b0  = hin;
                    m_cnt = 1;
                end else begin
                    m_b1    = hin;
                    m_state = layout(m_b0, m_b1);
                    m_valid = 1'b1;
                    m_cnt   = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("outValid", {127'b0, outValid}, {127'b0, m_valid});
            check("beatIdx", {127'b0, beatIdx}, {127'b0, m_cnt == 1});
            check("inReady", {127'b0, inReady}, {127'b0, (m_cnt < 2) || outReady});
            if (m_valid) check("stateOut", stateOut, m_state);
            if (outValid && outReady) pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        inValid = v;
        {hr0, hr1, hr2, hr3} = d;
    endtask

    initial begin
        int p0;
        step();
        step();
        run = 1'b1;
        @(negedge clk);
        check("rst_outValid", {127'b0, outValid}, 128'd0);
        check("rst_stateOut", stateOut, 128'd0);
        check("rst_inReady", {127'b0, inReady}, 128'd1);
        check("rst_beatIdx", {127'b0, beatIdx}, 128'd0);

        // Basic two-beat assembly
        rst_n = 1'b1;
        outReady = 1'b1;
        drive(1'b1, V0); step();
        drive(1'b1, V1); step();
        drive(1'b0, '0);
        @(negedge clk);
        check("lat_outValid", {127'b0, outValid}, 128'd1);
        check("basic_state", stateOut, EXP_LIT);
        check("model_pin", layout(V0, V1), EXP_LIT);
        step();

        // Output stall with a pending beat
        outReady = 1'b0;
        drive(1'b1, V0 ^ K); step();
        drive(1'b1, V1 ^ K); step();
        drive(1'b1, V0);
        repeat (5) step();
        @(negedge clk);
        check("stall_inReady", {127'b0, inReady}, 128'd0);
        check("stall_outValid", {127'b0, outValid}, 128'd1);
        outReady = 1'b1;
        step();
        drive(1'b0, '0);
        @(negedge clk);
        check("release_beatIdx", {127'b0, beatIdx}, 128'd1);
        check("release_outValid", {127'b0, outValid}, 128'd0);
        drive(1'b1, V1); step();
        drive(1'b0, '0);
        @(negedge clk);
        check("stall_state", stateOut, EXP_LIT);
        step();

        // Back-to-back stream of four states
        p0 = pulses;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, V0 + 64'(k) * K); step();
            drive(1'b1, V1 + 64'(k) * K); step();
        end
        drive(1'b0, '0);
        step();
        step();
        check("stream_pulses", 128'(pulses - p0), 128'd4);

        // Clear in HALF with a concurrent beat
        drive(1'b1, V0 ^ K); step();
        clear = 1'b1;
        drive(1'b1, V1 ^ K); step();
        clear = 1'b0;
        drive(1'b0, '0);
        @(negedge clk);
        check("clear_beatIdx", {127'b0, beatIdx}, 128'd0);
        check("clear_outValid", {127'b0, outValid}, 128'd0);
        drive(1'b1, V0); step();
        drive(1'b1, V1); step();
        drive(1'b0, '0);
        @(negedge clk);
        check("clear_state", stateOut, EXP_LIT);

        // Reset while FULL
        outReady = 1'b0;
        step();
        @(negedge clk);
        check("full_outValid", {127'b0, outValid}, 128'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_outValid", {127'b0, outValid}, 128'd0);
        check("rst2_stateOut", stateOut, 128'd0);
        check("rst2_inReady", {127'b0, inReady}, 128'd1);
        check("rst2_beatIdx", {127'b0, beatIdx}, 128'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
